// File: rtl/clock_mode_ctrl_pkg.sv
// Shared constants and helpers for the digital-clock user-input controller.
// Mode and field encodings must stay in step with the DigitalClock datapath.
package clock_mode_ctrl_pkg;

    localparam int MEGA = 1_000_000;

    localparam logic [1:0] MODE_CLOCK      = 2'd0;
    localparam logic [1:0] MODE_CLOCK_EDIT = 2'd1;
    localparam logic [1:0] MODE_ALARM_EDIT = 2'd2;
    localparam logic [1:0] MODE_STOPWATCH  = 2'd3;

    localparam logic [1:0] SELECT_NONE = 2'd0;
    localparam logic [1:0] SELECT_SEC  = 2'd1;
    localparam logic [1:0] SELECT_MIN  = 2'd2;
    localparam logic [1:0] SELECT_HOUR = 2'd3;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    function automatic int ms_to_cycles(input int clk_freq, input int ms);
        return (clk_freq / 1000) * ms;
    endfunction

    function automatic logic is_edit_mode(input logic [1:0] m);
        return (m == MODE_CLOCK_EDIT) || (m == MODE_ALARM_EDIT);
    endfunction

    // Edit-field rotation; NONE is never produced so an edit mode always has a field.
    function automatic logic [1:0] next_select(input logic [1:0] s);
        logic [1:0] n;
        case (s)
            SELECT_SEC:  n = SELECT_MIN;
            SELECT_MIN:  n = SELECT_HOUR;
            SELECT_HOUR: n = SELECT_SEC;
            default:     n = SELECT_SEC;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/clock_mode_ctrl_button_debounce.sv
// One push-button input path: 2-FF synchroniser, stability counter, debounced
// level and a registered one-cycle press pulse on its rising edge.
module button_debounce
    import clock_mode_ctrl_pkg::*;
#(
    parameter int CLK_FREQ    = 100 * MEGA,
    parameter int DEBOUNCE_MS = 10
) (
    input  logic clk,
    input  logic global_reset_n,
    input  logic btn_in,
    output logic level,
    output logic press
);

    localparam int             DEB_CYC = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);
    localparam int             CW      = $clog2(DEB_CYC + 1);
    localparam logic [CW-1:0]  DEB_MAX = CW'(DEB_CYC);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1'b1);
    localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          armed_q, armed_d;

    // Next-state: the counter reloads on the cycle the synchronised level changes.
    // A press needs the level to have been seen low since reset, so a button held
    // through reset stays silent until it is released and pressed again.
    always_comb begin
        sync_d = {sync_q[0], btn_in};
        if (sync_q[0] != sync_q[1]) begin
            cnt_d = CNT_ZERO;
        end else if (cnt_q != DEB_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
        if (cnt_d == DEB_MAX) begin
            level_d = sync_q[1];
        end else begin
            level_d = level_q;
        end
        if ((cnt_d == DEB_MAX) && !sync_q[1]) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_q;
        end
        press_d = level_d & ~level_q & armed_q;
    end

    // State registers.
    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            sync_q  <= 2'b00;
            cnt_q   <= CNT_ZERO;
            level_q <= 1'b0;
            press_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            armed_q <= armed_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/clock_mode_ctrl.sv
// User-input controller for the digital clock: turns three debounced buttons into
// mode/field selection, increment pulses with hold-to-repeat, alarm arm and stopwatch control.
module clock_mode_ctrl
    import clock_mode_ctrl_pkg::*;
#(
    parameter int CLK_FREQ        = 100 * MEGA,
    parameter int DEBOUNCE_MS     = 10,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100,
    parameter int NUM_MODES       = 4
) (
    input  logic       clk,
    input  logic       global_reset_n,
    input  logic       btn_mode,
    input  logic       btn_select,
    input  logic       btn_inc,
    output logic [1:0] mode,
    output logic [1:0] select,
    output logic       increment,
    output logic       alarm_enable,
    output logic       sw_run,
    output logic       sw_clear
);

    localparam int DLY_CYC = ms_to_cycles(CLK_FREQ, REPEAT_DELAY_MS);
    localparam int RPT_CYC = ms_to_cycles(CLK_FREQ, REPEAT_RATE_MS);
    localparam int CNT_MAX = (DLY_CYC > RPT_CYC) ? DLY_CYC : RPT_CYC;
    localparam int RW      = $clog2(CNT_MAX + 1);

    localparam logic [RW-1:0] DLY_END  = RW'(DLY_CYC);
    localparam logic [RW-1:0] RPT_END  = RW'(RPT_CYC);
    localparam logic [RW-1:0] CNT_SAT  = RW'(CNT_MAX);
    localparam logic [RW-1:0] CNT_ONE  = RW'(1'b1);
    localparam logic [RW-1:0] CNT_ZERO = {RW{1'b0}};
    localparam logic [1:0]    MODE_LAST = 2'(NUM_MODES - 1);

    logic mode_lvl_s, sel_lvl_s, inc_lvl_s;
    logic mode_press_s, sel_press_s, inc_press_s;
    logic unused_lvl_s;
    logic [1:0] next_mode_s;

    logic [1:0]    mode_q, mode_d;
    logic [1:0]    select_q, select_d;
    logic          increment_q, increment_d;
    logic          alarm_enable_q, alarm_enable_d;
    logic          sw_run_q, sw_run_d;
    logic          sw_clear_q, sw_clear_d;
    rpt_state_e    rpt_state_q, rpt_state_d;
    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;

    button_debounce #(.CLK_FREQ(CLK_FREQ), .DEBOUNCE_MS(DEBOUNCE_MS)) u_deb_mode (
        .clk(clk), .global_reset_n(global_reset_n), .btn_in(btn_mode),
        .level(mode_lvl_s), .press(mode_press_s)
    );
    button_debounce #(.CLK_FREQ(CLK_FREQ), .DEBOUNCE_MS(DEBOUNCE_MS)) u_deb_select (
        .clk(clk), .global_reset_n(global_reset_n), .btn_in(btn_select),
        .level(sel_lvl_s), .press(sel_press_s)
    );
    button_debounce #(.CLK_FREQ(CLK_FREQ), .DEBOUNCE_MS(DEBOUNCE_MS)) u_deb_inc (
        .clk(clk), .global_reset_n(global_reset_n), .btn_in(btn_inc),
        .level(inc_lvl_s), .press(inc_press_s)
    );

    // Only the inc level matters (for repeat); the other two are press-only.
    assign unused_lvl_s = mode_lvl_s ^ sel_lvl_s;
    assign next_mode_s  = (mode_q == MODE_LAST) ? MODE_CLOCK : (mode_q + 2'd1);

    // Next-state: repeat timer first, then presses in priority mode > select > inc.
    always_comb begin
        mode_d         = mode_q;
        select_d       = select_q;
        alarm_enable_d = alarm_enable_q;
        sw_run_d       = sw_run_q;
        sw_clear_d     = 1'b0;
        increment_d    = 1'b0;
        rpt_state_d    = rpt_state_q;
        rpt_cnt_d      = rpt_cnt_q;

        case (rpt_state_q)
            RPT_IDLE: begin
                rpt_cnt_d = CNT_ZERO;
            end
            RPT_DELAY, RPT_REPEAT: begin
                if (!inc_lvl_s) begin
                    rpt_state_d = RPT_IDLE;
                    rpt_cnt_d   = CNT_ZERO;
                end else if (rpt_cnt_q == ((rpt_state_q == RPT_DELAY) ? DLY_END : RPT_END)) begin
                    rpt_state_d = RPT_REPEAT;
                    rpt_cnt_d   = CNT_ONE;
                    increment_d = 1'b1;
                end else if (rpt_cnt_q != CNT_SAT) begin
                    rpt_cnt_d = rpt_cnt_q + CNT_ONE;
                end else begin
                    rpt_cnt_d = rpt_cnt_q;
                end
            end
            default: begin
                rpt_state_d = RPT_IDLE;
                rpt_cnt_d   = CNT_ZERO;
            end
        endcase

        if (mode_press_s) begin
            mode_d      = next_mode_s;
            select_d    = is_edit_mode(next_mode_s) ? SELECT_SEC : SELECT_NONE;
            increment_d = 1'b0;
            rpt_state_d = RPT_IDLE;
            rpt_cnt_d   = CNT_ZERO;
        end else if (sel_press_s) begin
            case (mode_q)
                MODE_CLOCK:                      alarm_enable_d = ~alarm_enable_q;
                MODE_CLOCK_EDIT, MODE_ALARM_EDIT: select_d      = next_select(select_q);
                MODE_STOPWATCH: begin
                    sw_clear_d = 1'b1;
                    sw_run_d   = 1'b0;
                end
                default:                         select_d       = select_q;
            endcase
        end else if (inc_press_s) begin
            case (mode_q)
                MODE_CLOCK_EDIT, MODE_ALARM_EDIT: begin
                    increment_d = 1'b1;
                    rpt_state_d = RPT_DELAY;
                    rpt_cnt_d   = CNT_ONE;
                end
                MODE_STOPWATCH: sw_run_d = ~sw_run_q;
                default:        sw_run_d = sw_run_q;
            endcase
        end else begin
            mode_d = mode_q;
        end
    end

    // Control and repeat-FSM registers; all outputs come straight from here.
    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            mode_q         <= MODE_CLOCK;
            select_q       <= SELECT_NONE;
            increment_q    <= 1'b0;
            alarm_enable_q <= 1'b0;
            sw_run_q       <= 1'b0;
            sw_clear_q     <= 1'b0;
            rpt_state_q    <= RPT_IDLE;
            rpt_cnt_q      <= CNT_ZERO;
        end else begin
            mode_q         <= mode_d;
            select_q       <= select_d;
            increment_q    <= increment_d;
            alarm_enable_q <= alarm_enable_d;
            sw_run_q       <= sw_run_d;
            sw_clear_q     <= sw_clear_d;
            rpt_state_q    <= rpt_state_d;
            rpt_cnt_q      <= rpt_cnt_d;
        end
    end

    assign mode         = mode_q;
    assign select       = select_q;
    assign increment    = increment_q;
    assign alarm_enable = alarm_enable_q;
    assign sw_run       = sw_run_q;
    assign sw_clear     = sw_clear_q;

endmodule
